// File: rtl/twiddle8_conj_pipe_pkg.sv
// Shared FFT package: twiddle codes, default data width and the 1/sqrt2
// shift-add constants used by both the forward and inverse twiddle multipliers.
package twiddle8_conj_pipe_pkg;

    localparam logic [1:0] TW_0 = 2'd0;
    localparam logic [1:0] TW_1 = 2'd1;
    localparam logic [1:0] TW_2 = 2'd2;
    localparam logic [1:0] TW_3 = 2'd3;

    localparam int DATA_W_DEFAULT = 10;

    // y = x - ((x - x/16) * 5/4) / 4  ~=  x * 0.7070
    localparam int SQ_SH_A = 4;
    localparam int SQ_SH_B = 2;
    localparam int SQ_SH_C = 2;

endpackage

// File: rtl/twiddle8_conj_pipe_inv_sqrt2_scale.sv
// Combinational shift-add approximation of x/sqrt2, floor semantics throughout.
module inv_sqrt2_scale
    import twiddle8_conj_pipe_pkg::*;
#(
    parameter int W = DATA_W_DEFAULT + 1
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    localparam int WE = W + 1;

    // t2 peaks near 1.17*|x|, so one guard bit keeps the intermediates exact;
    // the final result always fits back into W bits.
    logic signed [WE-1:0] xe, t1, t2;

    assign xe = WE'($signed(x));
    assign t1 = xe - (xe >>> SQ_SH_A);
    assign t2 = t1 + (t1 >>> SQ_SH_B);
    assign y  = $signed(x) - W'(t2 >>> SQ_SH_C);

endmodule

// File: rtl/twiddle8_conj_pipe.sv
// Two-stage conjugate radix-8 twiddle multiplier (x * e^(+j*pi*k/4)) with
// valid/ready handshake and frame-end tagging on the output stream.
module twiddle8_conj_pipe
    import twiddle8_conj_pipe_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = DATA_W_DEFAULT,
    parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
    parameter int FRAME_LEN      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                twiddle,
    input  logic [DATA_WIDTH_IN-1:0]  din_real,
    input  logic [DATA_WIDTH_IN-1:0]  din_imag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH_OUT-1:0] dout_real,
    output logic [DATA_WIDTH_OUT-1:0] dout_imag,
    output logic                      out_last
);
    localparam int W  = DATA_WIDTH_OUT;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic          s1_valid, s1_scale, s1_last;
    logic [W-1:0]  s1_p, s1_q;
    logic          en1, en2, in_fire, last_in;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a, b, p_nx, q_nx, p_sc, q_sc;

    assign en2       = !out_valid || out_ready;
    assign en1       = !s1_valid || en2;
    assign in_ready  = en1;
    assign in_fire   = in_valid && en1;
    assign last_in   = (cnt == CW'(FRAME_LEN - 1));

    assign a = W'($signed(din_real));
    assign b = W'($signed(din_imag));

    always_comb begin
        p_nx = a;
        q_nx = b;
        case (twiddle)
            TW_0: begin p_nx = a;      q_nx = b;     end
            TW_1: begin p_nx = a - b;  q_nx = a + b; end
            TW_2: begin p_nx = -b;     q_nx = a;     end
            default: begin p_nx = -a - b; q_nx = a - b; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (in_fire) begin
            cnt <= last_in ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_last  <= 1'b0;
            s1_p     <= '0;
            s1_q     <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_scale <= twiddle[0];
                s1_last  <= last_in;
                s1_p     <= p_nx;
                s1_q     <= q_nx;
            end
        end
    end

    inv_sqrt2_scale #(.W(W)) u_scale_p (.x(s1_p), .y(p_sc));
    inv_sqrt2_scale #(.W(W)) u_scale_q (.x(s1_q), .y(q_sc));

    // S2 holds its data while stalled; out_last only asserts alongside a valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            dout_real <= '0;
            dout_imag <= '0;
        end else if (en2) begin
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                dout_real <= s1_scale ? p_sc : s1_p;
                dout_imag <= s1_scale ? q_sc : s1_q;
            end
        end
    end

endmodule

// File: tb/tb_twiddle8_conj_pipe.sv
// Directed bench for twiddle8_conj_pipe: vector table, framing, stall and reset sequences.
module tb_twiddle8_conj_pipe;

    localparam int WI = 10;
    localparam int WO = 11;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    twiddle = 2'd0;
    logic [WI-1:0] din_real = '0;
    logic [WI-1:0] din_imag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WO-1:0] dout_real;
    logic [WO-1:0] dout_imag;
    logic          out_last;

    twiddle8_conj_pipe #(.DATA_WIDTH_IN(WI), .DATA_WIDTH_OUT(WO), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .twiddle(twiddle), .din_real(din_real), .din_imag(din_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_real(dout_real), .dout_imag(dout_imag), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] k; int a; int b; int er; int ei; } vec_t;
    typedef struct { int last; int re; int im; } smp_t;

    int total = 0;
    int bad = 0;
    smp_t exp_q[$];
    smp_t got_q[$];
    int tb_cnt = 0;
    int saw_ready_low = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic int isq(input int x);
        int t1, t2;
        t1 = x - (x >>> 4);
        t2 = t1 + (t1 >>> 2);
        return x - (t2 >>> 2);
    endfunction

    function automatic smp_t model(input int k, input int a, input int b, input int last);
        smp_t s;
        int p, q;
        case (k)
            0: begin p = a; q = b; end
            1: begin p = isq(a - b); q = isq(a + b); end
            2: begin p = -b; q = a; end
            default: begin p = isq(-a - b); q = isq(a - b); end
        endcase
        s.last = last; s.re = p; s.im = q;
        return s;
    endfunction

    // Output monitor: collect transfers, and check outputs stay frozen during stalls.
    logic          held = 1'b0;
    logic [WO-1:0] h_re, h_im;
    logic          h_last;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid_hold", int'(out_valid), 1);
                chk("stall_re_hold", int'($signed(dout_real)), int'($signed(h_re)));
                chk("stall_im_hold", int'($signed(dout_imag)), int'($signed(h_im)));
                chk("stall_last_hold", int'(out_last), int'(h_last));
            end
            if (out_valid && out_ready)
                got_q.push_back('{int'(out_last), int'($signed(dout_real)), int'($signed(dout_imag))});
            if (!in_ready) saw_ready_low = 1;
            held = out_valid && !out_ready;
            h_re = dout_real; h_im = dout_imag; h_last = out_last;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); got_q.delete(); tb_cnt = 0; saw_ready_low = 0;
    endtask

    // Push n samples, holding each until accepted; out_ready low for cycles [slo,shi).
    task automatic stream(input int n, input int slo, input int shi);
        int i = 0;
        int c = 0;
        int a, b, k;
        while (i < n && c < 200) begin
            @(posedge clk); #1;
            out_ready = !(c >= slo && c < shi);
            k = i % 4;
            a = ((i * 37) % 200) - 100;
            b = 90 - ((i * 53) % 180);
            in_valid = 1'b1; twiddle = 2'(k);
            din_real = WI'(a); din_imag = WI'(b);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(k, a, b, int'(tb_cnt == FL - 1)));
                tb_cnt = (tb_cnt == FL - 1) ? 0 : tb_cnt + 1;
                i++;
            end
            c++;
        end
        if (i < n) chk("stream_accept_timeout", i, n);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic compare_queues(input string nm);
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_re[%0d]", nm, i), got_q[i].re, exp_q[i].re);
            chk($sformatf("%s_im[%0d]", nm, i), got_q[i].im, exp_q[i].im);
            chk($sformatf("%s_last[%0d]", nm, i), got_q[i].last, exp_q[i].last);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{2'd0,  100,  -50,  100,  -50};
        vecs[1] = '{2'd2,   60,   40,  -40,   60};
        vecs[2] = '{2'd1,   60,   40,   15,   71};
        vecs[3] = '{2'd3,   60,   40,  -70,   15};
        vecs[4] = '{2'd1, -512, -512,    0, -724};

        do_reset();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_dout_real", int'(dout_real), 0);
        chk("rst_dout_imag", int'(dout_imag), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Single samples: accept, then result appears two edges later.
        foreach (vecs[v]) begin
            @(posedge clk); #1;
            in_valid = 1'b1; twiddle = vecs[v].k;
            din_real = WI'(vecs[v].a); din_imag = WI'(vecs[v].b);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", v), int'(in_ready), 1);
            @(posedge clk); #1;
            in_valid = 1'b0; twiddle = 2'(v + 1); din_real = '1; din_imag = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_early_valid", v), int'(out_valid), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", v), int'(out_valid), 1);
            chk($sformatf("vec%0d_re", v), int'($signed(dout_real)), vecs[v].er);
            chk($sformatf("vec%0d_im", v), int'($signed(dout_imag)), vecs[v].ei);
            chk($sformatf("vec%0d_last", v), int'(out_last), 0);
        end

        // Framing: 9 back-to-back samples, last only on the 8th.
        do_reset();
        stream(9, 1000, 1000);
        compare_queues("frame");
        if (got_q.size() == 9) begin
            chk("frame_last8", got_q[7].last, 1);
            chk("frame_last9", got_q[8].last, 0);
        end

        // Backpressure mid-stream.
        do_reset();
        stream(6, 2, 5);
        compare_queues("stall");
        chk("stall_in_ready_dropped", saw_ready_low, 1);

        // Reset with two samples in flight.
        do_reset();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; twiddle = 2'd0; din_real = WI'(11); din_imag = WI'(22);
        @(posedge clk); #1;
        din_real = WI'(33); din_imag = WI'(44);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flight_out_valid", int'(out_valid), 1);
        chk("flight_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_dout_real", int'(dout_real), 0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        exp_q.delete(); got_q.delete(); tb_cnt = 0;
        stream(FL, 1000, 1000);
        compare_queues("postrst");
        if (got_q.size() == FL) chk("postrst_last", got_q[FL-1].last, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
